// File: rtl/riscv_instr_encoder.sv
// RV32I encoder: decomposed fields + format tag in, packed instruction word plus sequential address out.
// Latency 2 cycles at 1 word/cycle; holds up to 2 words under out_ready backpressure, in_ready never looks at in_valid.
module riscv_instr_encoder #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_type,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  input  logic                 addr_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0]  T_R = 3'b000;
  localparam logic [2:0]  T_I = 3'b001;
  localparam logic [2:0]  T_S = 3'b010;
  localparam logic [2:0]  T_B = 3'b011;
  localparam logic [2:0]  T_U = 3'b100;
  localparam logic [2:0]  T_J = 3'b101;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  typ;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  fields_t     s1;
  logic        s1_vld;
  logic        s2_adv;
  logic        s1_ok;
  logic [31:0] s1_word;
  logic [31:0] imm;
  logic        out_hs;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_vld || s2_adv;
  assign out_hs   = out_valid && out_ready;
  assign imm      = s1.imm;

  // Range checks: the bits above the encodable field must all be sign copies.
  always_comb begin
    s1_ok   = 1'b0;
    s1_word = NOP;
    case (s1.typ)
      T_R: begin
        s1_ok   = 1'b1;
        s1_word = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, s1.opcode};
      end
      T_I: begin
        s1_ok   = (&imm[31:11]) || !(|imm[31:11]);
        s1_word = {imm[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
      end
      T_S: begin
        s1_ok   = (&imm[31:11]) || !(|imm[31:11]);
        s1_word = {imm[11:5], s1.rs2, s1.rs1, s1.funct3, imm[4:0], s1.opcode};
      end
      T_B: begin
        s1_ok   = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
        s1_word = {imm[12], imm[10:5], s1.rs2, s1.rs1, s1.funct3, imm[4:1], imm[11], s1.opcode};
      end
      T_U: begin
        s1_ok   = !(|imm[11:0]);
        s1_word = {imm[31:12], s1.rd, s1.opcode};
      end
      T_J: begin
        s1_ok   = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
        s1_word = {imm[20], imm[10:1], imm[11], imm[19:12], s1.rd, s1.opcode};
      end
      default: begin
        s1_ok   = 1'b0;
        s1_word = NOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1        <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= BASE_ADDR;
      err_cnt   <= '0;
    end else begin
      if (in_ready) begin
        s1_vld <= in_valid;
        if (in_valid)
          s1 <= {in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm};
      end
      if (s2_adv) begin
        out_valid <= s1_vld;
        if (s1_vld) begin
          out_instr <= s1_ok ? s1_word : NOP;
          out_err   <= !s1_ok;
        end
      end
      // A word handshaken together with addr_clr keeps its own address; the reload affects the next one.
      if (addr_clr)
        out_addr <= BASE_ADDR;
      else if (out_hs)
        out_addr <= out_addr + ADDR_W'(4);
      if (out_hs && out_err && !(&err_cnt))
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
